// File: rtl/ex_pkg.sv
// Shared types, opcode/exception constants and the squash helper for the EX/MEM stage register.
package ex_pkg;
    localparam int EX_WORD_W = 32;
    localparam int EX_ADDR_W = 30;
    localparam int EX_REG_W  = 5;

    localparam logic [1:0] MEM_OP_NOP = 2'd0;
    localparam logic [1:0] MEM_OP_LDW = 2'd1;
    localparam logic [1:0] MEM_OP_STW = 2'd2;

    localparam logic [1:0] CTRL_OP_NOP  = 2'd0;
    localparam logic [1:0] CTRL_OP_WRCR = 2'd1;
    localparam logic [1:0] CTRL_OP_EXRT = 2'd2;

    localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
    localparam logic [2:0] ISA_EXP_EXT_INT    = 3'd1;
    localparam logic [2:0] ISA_EXP_UNDEF_INSN = 3'd2;
    localparam logic [2:0] ISA_EXP_OVERFLOW   = 3'd3;
    localparam logic [2:0] ISA_EXP_TRAP       = 3'd5;

    typedef struct packed {
        logic [EX_ADDR_W-1:0] pc;
        logic                 br_flag;
        logic [1:0]           mem_op;
        logic [EX_WORD_W-1:0] mem_wr_data;
        logic [1:0]           ctrl_op;
        logic [EX_REG_W-1:0]  dst_addr;
        logic                 gpr_we_;
        logic [2:0]           exp_code;
    } ex_info_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam ex_info_t EX_INFO_RST = '{
        pc:          '0,
        br_flag:     1'b0,
        mem_op:      MEM_OP_NOP,
        mem_wr_data: '0,
        ctrl_op:     CTRL_OP_NOP,
        dst_addr:    '0,
        gpr_we_:     1'b1,
        exp_code:    ISA_EXP_NO_EXP
    };

    // A squashed beat keeps only its pc/br_flag so the exception handler can locate it.
    function automatic ex_info_t ex_squash(input ex_info_t info, input logic [2:0] code);
        ex_info_t s;
        s          = EX_INFO_RST;
        s.pc       = info.pc;
        s.br_flag  = info.br_flag;
        s.exp_code = code;
        return s;
    endfunction
endpackage

// File: rtl/ex_exc_tag.sv
// Combinational exception tagger: prioritises int_detect over alu_of over the incoming exp_code.
module ex_exc_tag
    import ex_pkg::*;
#(
    parameter int WORD_W = EX_WORD_W
) (
    input  logic              int_detect,
    input  logic              alu_of,
    input  ex_info_t          info,
    input  logic [WORD_W-1:0] alu_out,
    output ex_info_t          tag_info,
    output logic [WORD_W-1:0] tag_data,
    output logic              is_exc
);
    always_comb begin
        tag_info = info;
        tag_data = alu_out;
        is_exc   = 1'b0;
        if (int_detect) begin
            tag_info = ex_squash(info, ISA_EXP_EXT_INT);
            tag_data = '0;
            is_exc   = 1'b1;
        end else if (alu_of) begin
            tag_info = ex_squash(info, ISA_EXP_OVERFLOW);
            tag_data = '0;
            is_exc   = 1'b1;
        end
    end
endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with optional skid entry (macro EX_MEM_SKID_REG_SKID_EN) and exception counter.
module ex_mem_skid_reg
    import ex_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 30,
    parameter int INFO_W = $bits(ex_info_t)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              int_detect,
    input  logic              alu_of,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INFO_W-1:0] in_info,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INFO_W-1:0] out_info,
    output logic [WORD_W-1:0] out_data,
    output logic [15:0]       exc_cnt
);
    localparam int PC_SHIFT = (ADDR_W >= EX_ADDR_W) ? 0 : EX_ADDR_W - ADDR_W;
    localparam logic [EX_ADDR_W-1:0] PC_MASK = {EX_ADDR_W{1'b1}} >> PC_SHIFT;

    ex_info_t          tag_in;
    ex_info_t          tag_info;
    ex_info_t          head_info;
    logic [WORD_W-1:0] tag_data;
    logic [WORD_W-1:0] head_data;
    logic              is_exc;
    logic              accept;
    logic              pop;
    logic              load_in;
    occ_t              state;
    occ_t              state_n;

    always_comb begin
        tag_in    = ex_info_t'(in_info);
        tag_in.pc = tag_in.pc & PC_MASK;
    end

    ex_exc_tag #(.WORD_W(WORD_W)) u_tag (
        .int_detect (int_detect),
        .alu_of     (alu_of),
        .info       (tag_in),
        .alu_out    (alu_out),
        .tag_info   (tag_info),
        .tag_data   (tag_data),
        .is_exc     (is_exc)
    );

    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != OCC_EMPTY);
    assign out_info  = head_info;
    assign out_data  = head_data;

`ifdef EX_MEM_SKID_REG_SKID_EN
    ex_info_t          skid_info;
    logic [WORD_W-1:0] skid_data;
    logic              load_skid;
    logic              load_from_skid;

    always_comb begin
        state_n        = state;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        if (flush) begin
            state_n = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) begin
                    state_n = OCC_ONE;
                    load_in = 1'b1;
                end
                OCC_ONE: if (accept && pop) begin
                    load_in = 1'b1;
                end else if (pop) begin
                    state_n = OCC_EMPTY;
                end else if (accept) begin
                    state_n   = OCC_FULL;
                    load_skid = 1'b1;
                end
                OCC_FULL: if (pop) begin
                    state_n        = OCC_ONE;
                    load_from_skid = 1'b1;
                end
                default: state_n = OCC_EMPTY;
            endcase
        end
    end

    // in_ready is a flop so out_ready never reaches upstream combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready <= 1'b1;
        else       in_ready <= (state_n != OCC_FULL);
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_info <= tag_info;
            skid_data <= tag_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OCC_EMPTY;
            head_info <= EX_INFO_RST;
            head_data <= '0;
        end else begin
            state <= state_n;
            if (load_in) begin
                head_info <= tag_info;
                head_data <= tag_data;
            end else if (load_from_skid) begin
                head_info <= skid_info;
                head_data <= skid_data;
            end
        end
    end
`else
    // Single entry: an accept while occupied always coincides with a pop.
    always_comb begin
        state_n = state;
        load_in = 1'b0;
        if (flush) begin
            state_n = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) begin
                    state_n = OCC_ONE;
                    load_in = 1'b1;
                end
                OCC_ONE: if (accept) begin
                    load_in = 1'b1;
                end else if (pop) begin
                    state_n = OCC_EMPTY;
                end
                default: state_n = OCC_EMPTY;
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OCC_EMPTY;
            head_info <= EX_INFO_RST;
            head_data <= '0;
        end else begin
            state <= state_n;
            if (load_in) begin
                head_info <= tag_info;
                head_data <= tag_data;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   exc_cnt <= '0;
        else if (accept && is_exc && exc_cnt != '1)  exc_cnt <= exc_cnt + 16'd1;
    end
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg; expectations follow the build selected by EX_MEM_SKID_REG_SKID_EN.
module tb_ex_mem_skid_reg;
    import ex_pkg::*;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;
    localparam int INFO_W = $bits(ex_info_t);

    typedef struct packed {
        ex_info_t    info;
        logic [31:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              int_detect;
    logic              alu_of;
    logic [WORD_W-1:0] alu_out;
    logic              in_valid;
    logic              in_ready;
    logic [INFO_W-1:0] in_info;
    logic              out_valid;
    logic              out_ready;
    logic [INFO_W-1:0] out_info;
    logic [WORD_W-1:0] out_data;
    logic [15:0]       exc_cnt;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .INFO_W(INFO_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .int_detect (int_detect),
        .alu_of     (alu_of),
        .alu_out    (alu_out),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_info    (in_info),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_info   (out_info),
        .out_data   (out_data),
        .exc_cnt    (exc_cnt)
    );

    function automatic ex_info_t mk(input logic [29:0] pc, input logic br, input logic [1:0] mop,
                                    input logic [31:0] wd, input logic [1:0] cop, input logic [4:0] dst,
                                    input logic we_, input logic [2:0] ec);
        ex_info_t r;
        r.pc = pc; r.br_flag = br; r.mem_op = mop; r.mem_wr_data = wd;
        r.ctrl_op = cop; r.dst_addr = dst; r.gpr_we_ = we_; r.exp_code = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [29:0] head_pc();
        ex_info_t o;
        o = ex_info_t'(out_info);
        return o.pc;
    endfunction

    // Monitor: every beat leaving the stage is compared against the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got pc %0h, required no beat", head_pc());
            end else begin
                e = exp_q.pop_front();
                chk("beat_info", out_info, e.info);
                chk("beat_data", out_data, e.data);
            end
        end
    end

    // Offer one beat; push its hand-computed expectation when it is accepted.
    task automatic send(input ex_info_t i, input logic [31:0] d, input logic intd, input logic ovf,
                        input ex_info_t ei, input logic [31:0] ed);
        int n;
        n = 0;
        in_valid = 1'b1; in_info = i; alu_out = d; int_detect = intd; alu_of = ovf;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for pc %0h, required 1", i.pc);
        end else begin
            exp_q.push_back('{info: ei, data: ed});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; int_detect = 1'b0; alu_of = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_info_t a, b, c, x, y, z, ex, ey, ein, eov;
        ex_info_t rst_info;
        rst_info = mk(30'h0, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_NO_EXP);

        reset = 1'b1; flush = 1'b0; int_detect = 1'b0; alu_of = 1'b0; alu_out = '0;
        in_valid = 1'b0; in_info = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_exc_cnt", exc_cnt, 16'h0);
        chk("rst_out_info", out_info, rst_info);
        chk("rst_out_data", out_data, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // First beat, one-cycle latency
        out_ready = 1'b1;
        a = mk(30'h100, 1'b0, MEM_OP_LDW, 32'h0, CTRL_OP_NOP, 5'd3, 1'b0, ISA_EXP_NO_EXP);
        send(a, 32'hDEADBEEF, 1'b0, 1'b0, a, 32'hDEADBEEF);
        chk("first_out_valid", out_valid, 1'b1);
        chk("first_out_data", out_data, 32'hDEADBEEF);
        chk("first_pc", head_pc(), 30'h100);
        drain();

        // Backpressure with three beats
        a = mk(30'h200, 1'b1, MEM_OP_LDW, 32'h0, CTRL_OP_NOP, 5'd1, 1'b0, ISA_EXP_NO_EXP);
        b = mk(30'h204, 1'b0, MEM_OP_STW, 32'hCAFE0000, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_NO_EXP);
        c = mk(30'h208, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_WRCR, 5'd2, 1'b0, ISA_EXP_NO_EXP);
        out_ready = 1'b0;
        send(a, 32'h11111111, 1'b0, 1'b0, a, 32'h11111111);
`ifdef EX_MEM_SKID_REG_SKID_EN
        send(b, 32'h22222222, 1'b0, 1'b0, b, 32'h22222222);
        chk("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_info = c; alu_out = 32'h33333333;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_head_pc", head_pc(), 30'h200);
        end
        out_ready = 1'b1;
        send(c, 32'h33333333, 1'b0, 1'b0, c, 32'h33333333);
`else
        chk("single_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b1; in_info = b; alu_out = 32'h22222222;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_head_pc", head_pc(), 30'h200);
        end
        out_ready = 1'b1;
        #1;
        chk("single_in_ready_high", in_ready, 1'b1);
        send(b, 32'h22222222, 1'b0, 1'b0, b, 32'h22222222);
        send(c, 32'h33333333, 1'b0, 1'b0, c, 32'h33333333);
`endif
        drain();

        // Exception tagging and priority
        out_ready = 1'b1;
        x  = mk(30'h40, 1'b1, MEM_OP_STW, 32'h1234, CTRL_OP_WRCR, 5'd5, 1'b0, ISA_EXP_NO_EXP);
        ex = mk(30'h40, 1'b1, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_EXT_INT);
        send(x, 32'h99, 1'b1, 1'b1, ex, 32'h0);
        chk("int_exc_cnt", exc_cnt, 16'd1);
        chk("int_out_data", out_data, 32'h0);
        chk("int_pc", head_pc(), 30'h40);
        y  = mk(30'h44, 1'b0, MEM_OP_LDW, 32'h0, CTRL_OP_NOP, 5'd7, 1'b0, ISA_EXP_UNDEF_INSN);
        ey = mk(30'h44, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_OVERFLOW);
        send(y, 32'h55, 1'b0, 1'b1, ey, 32'h0);
        chk("ovf_exc_cnt", exc_cnt, 16'd2);
        z = mk(30'h48, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_EXRT, 5'd4, 1'b0, ISA_EXP_TRAP);
        send(z, 32'h77, 1'b0, 1'b0, z, 32'h77);
        chk("plain_exc_cnt", exc_cnt, 16'd2);
        int_detect = 1'b1; alu_of = 1'b1;
        @(posedge clk); #1;
        int_detect = 1'b0; alu_of = 1'b0;
        chk("idle_exc_cnt", exc_cnt, 16'd2);
        drain();

        // Flush with an incoming exception beat
        out_ready = 1'b0;
        a = mk(30'h300, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd9, 1'b0, ISA_EXP_NO_EXP);
        send(a, 32'hA0, 1'b0, 1'b0, a, 32'hA0);
`ifdef EX_MEM_SKID_REG_SKID_EN
        b = mk(30'h304, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd10, 1'b0, ISA_EXP_NO_EXP);
        send(b, 32'hA4, 1'b0, 1'b0, b, 32'hA4);
`endif
        in_valid = 1'b1; in_info = mk(30'h308, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd11, 1'b0, ISA_EXP_NO_EXP);
        alu_out = 32'hA8; int_detect = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; int_detect = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_exc_cnt", exc_cnt, 16'd2);
        @(posedge clk); #1;
        chk("flush_stays_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        a = mk(30'h400, 1'b0, MEM_OP_LDW, 32'h0, CTRL_OP_NOP, 5'd12, 1'b0, ISA_EXP_NO_EXP);
        send(a, 32'hB0, 1'b0, 1'b0, a, 32'hB0);
        drain();

        // Counter saturation
        for (int i = 0; i < 65532; i++) begin
            ein = mk(30'(i), 1'b0, MEM_OP_STW, 32'h5, CTRL_OP_NOP, 5'd1, 1'b0, ISA_EXP_NO_EXP);
            eov = mk(30'(i), 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_OVERFLOW);
            send(ein, 32'(i), 1'b0, 1'b1, eov, 32'h0);
        end
        drain();
        chk("cnt_fffe", exc_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            ein = mk(30'h500, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd1, 1'b0, ISA_EXP_NO_EXP);
            eov = mk(30'h500, 1'b0, MEM_OP_NOP, 32'h0, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_OVERFLOW);
            send(ein, 32'h1, 1'b0, 1'b1, eov, 32'h0);
            chk("cnt_sat", exc_cnt, 16'hFFFF);
        end
        drain();

        // Asynchronous reset mid-transfer
        out_ready = 1'b0;
        a = mk(30'h600, 1'b1, MEM_OP_LDW, 32'h0, CTRL_OP_NOP, 5'd2, 1'b0, ISA_EXP_NO_EXP);
        send(a, 32'hC0, 1'b0, 1'b0, a, 32'hC0);
`ifdef EX_MEM_SKID_REG_SKID_EN
        b = mk(30'h604, 1'b0, MEM_OP_STW, 32'h7, CTRL_OP_NOP, 5'd0, 1'b1, ISA_EXP_NO_EXP);
        send(b, 32'hC4, 1'b0, 1'b0, b, 32'hC4);
`endif
        #3;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_exc_cnt", exc_cnt, 16'h0);
        chk("mid_rst_out_info", out_info, rst_info);
        chk("mid_rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_out_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
